seg7_result_display: RTL
========================

Name: seg7_result_display

Overview:
- Downstream display stage for the board ALU.
- Consumes the ALU's 9-bit result bus {carry,result} and its 4-bit operation-letter code, and drives a 4-digit multiplexed common-anode seven-segment display.
- Leftmost digit shows the operation letter; the right three digits show the unsigned decimal value 0..511.
- A multi-cycle double-dabble converter produces the decimal digits.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit (1 kHz per digit at 100 MHz); must be >= 2.
- BLANK_LEADING, 1, 1 = suppress leading zeros in the hundreds and tens digits; 0 = always show three digits.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- bin  input  9  ALU result {carry,result}, unsigned.
- letter  input  4  ALU op code: 4'hA, 4'hB, 4'hC, 4'h0.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  output  4  digit enables, active-low one-hot, registered; an[3] = leftmost.
- dp  output  1  decimal point, active-low; constant 1 (off).
- busy  output  1  high while a BCD conversion is in progress.

Behaviour:
- Reset (rst=1 at an edge) loads the following:
  - bcd_h/t/o=0, last_bin=0, conv state IDLE, busy=0.
  - refresh counter=0, digit index=0.
  - an=4'b1110, seg=7'b1000000 ('0'), dp=1.
  - Reset mid-conversion aborts it; the display regs still clear.
- Converter FSM, states IDLE, SHIFT, LATCH:
  - IDLE: if bin != last_bin at edge E, capture last_bin<=bin, shift reg<={12'b0,bin}, cnt<=0, busy<=1, go to SHIFT.
  - SHIFT: each cycle, add 3 to any BCD nibble >=5, then shift the 21-bit register left by 1, cnt++. After the 9th shift go to LATCH.
  - LATCH: copy the three nibbles to bcd_h/t/o, busy<=0, return to IDLE.
  - Latency: new digits visible in bcd regs after edge E+11.
  - bin changes during SHIFT/LATCH are ignored. On re-entering IDLE, bin is compared again, so the final value is always converted (no lost update; intermediate values may be skipped).
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1.
  - On wrap, digit index advances 0->1->2->3->0.
  - seg/an update on the same edge as the index change (one register stage).
  - Digit 0 = ones, 1 = tens, 2 = hundreds, 3 = letter.
- Blanking (BLANK_LEADING=1):
  - Hundreds blank when bcd_h=0.
  - Tens blank when bcd_h=0 and bcd_t=0.
  - Ones never blank.
  - A blank digit is still scanned, with seg=7'b1111111.
- Letter decode (sampled live during the digit-3 slot):
  - 4'hA: 'A' 0001000
  - 4'hB: 'b' 0000011
  - 4'hC: 'C' 1000110
  - 4'h0: blank 1111111
  - any other value: '-' 0111111
- Digit patterns (seg[6:0]):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- A nibble >9 cannot occur; decode it as '-'.
- Exactly one an bit is low at all times after reset.

Decomposition:
- Package seg7_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_A, SEG_B_LC, SEG_C, SEG_DASH, SEG_BLANK;
  - letter codes LTR_ADD_A=4'hA, LTR_B=4'hB, LTR_OP=4'hC, LTR_NONE=4'h0;
  - the converter state enum.
- One sub-module, bin2bcd_seq: the IDLE/SHIFT/LATCH double-dabble FSM, with outputs bcd_h/t/o and busy.
- Scan and decode logic stay in the top module.

Test Plan (REFRESH_DIV=4):
- Reset: rst=1 for 2 cycles, bin=0, letter=0 -> an=1110, seg=1000000, dp=1, busy=0. Over a full scan, digits 1..3 show 1111111.
- Conversion: bin=255, letter=4'hA.
  - busy=1 for edges E+1..E+10; bcd=2,5,5 at E+11.
  - Scan shows an=0111/0001000, 1011/0100100, 1101/0010010, 1110/0010010.
- Maximum value: bin=9'h1FF, letter=4'hC -> digits 5,1,1 and letter 1000110. With bin=9'd7, letter=4'h5: hundreds and tens blank, ones 1111000, letter '-' 0111111.
- Change mid-conversion: bin=100, then bin=42 three cycles later.
  - bcd first reads 1,0,0.
  - busy reasserts the cycle after LATCH.
  - bcd ends at 0,4,2.
- Reset mid-conversion: bin=300, rst pulsed at E+5 -> bcd=0,0,0, busy=0, an=1110.
  - With bin still 300 after reset release, a fresh conversion starts; 3,0,0 appears 11 edges later.
- BLANK_LEADING=0: bin=5 -> digits show 0,0,5 patterns 1000000, 1000000, 0010010.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the result display: segment patterns, ALU letter codes, converter states.
package seg7_pkg;

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B_LC  = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] LTR_ADD_A = 4'hA;
    localparam logic [3:0] LTR_B     = 4'hB;
    localparam logic [3:0] LTR_OP    = 4'hC;
    localparam logic [3:0] LTR_NONE  = 4'h0;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_LATCH = 2'd2
    } conv_state_t;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = SEG_0;
            4'd1:    digit_seg = SEG_1;
            4'd2:    digit_seg = SEG_2;
            4'd3:    digit_seg = SEG_3;
            4'd4:    digit_seg = SEG_4;
            4'd5:    digit_seg = SEG_5;
            4'd6:    digit_seg = SEG_6;
            4'd7:    digit_seg = SEG_7;
            4'd8:    digit_seg = SEG_8;
            4'd9:    digit_seg = SEG_9;
            default: digit_seg = SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seg7_result_display_bin2bcd_seq.sv
// Sequential double-dabble: 9-bit binary to three BCD nibbles, one shift per cycle.
// Starts whenever the input differs from the last converted value; results land 11 edges after the start edge.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] i_bin,
    output logic [3:0] o_bcd_h,
    output logic [3:0] o_bcd_t,
    output logic [3:0] o_bcd_o,
    output logic       o_busy
);

    conv_state_t r_state;
    conv_state_t w_state_nxt;
    logic [8:0]  r_last_bin;
    logic [20:0] r_shift;
    logic [20:0] w_adj;
    logic [3:0]  r_cnt;
    logic [3:0]  r_bcd_h, r_bcd_t, r_bcd_o;
    logic        r_busy;

    function automatic logic [3:0] add3(input logic [3:0] n);
        add3 = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_adj       = {add3(r_shift[20:17]), add3(r_shift[16:13]), add3(r_shift[12:9]), r_shift[8:0]};
        case (r_state)
            CONV_IDLE:  if (i_bin != r_last_bin) w_state_nxt = CONV_SHIFT;
            CONV_SHIFT: if (r_cnt == 4'd9) w_state_nxt = CONV_LATCH;
            CONV_LATCH: w_state_nxt = CONV_IDLE;
            default:    w_state_nxt = CONV_IDLE;
        endcase
    end

    // The cycle that sees cnt==9 only advances state, so LATCH lands on start+11
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CONV_IDLE;
            r_last_bin <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_bcd_h    <= '0;
            r_bcd_t    <= '0;
            r_bcd_o    <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                CONV_IDLE: begin
                    if (i_bin != r_last_bin) begin
                        r_last_bin <= i_bin;
                        r_shift    <= {12'b0, i_bin};
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                CONV_SHIFT: begin
                    if (r_cnt != 4'd9) begin
                        r_shift <= {w_adj[19:0], 1'b0};
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                CONV_LATCH: begin
                    r_bcd_h <= r_shift[20:17];
                    r_bcd_t <= r_shift[16:13];
                    r_bcd_o <= r_shift[12:9];
                    r_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_bcd_h = r_bcd_h;
    assign o_bcd_t = r_bcd_t;
    assign o_bcd_o = r_bcd_o;
    assign o_busy  = r_busy;

endmodule

// File: rtl/seg7_result_display.sv
// Four-digit multiplexed common-anode display of the ALU result: op letter on the left, decimal 0..511 on the right.
// seg/an are registered from the next digit index, so they change on the same edge as the scan index.
module seg7_result_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] bin,
    input  logic [3:0] letter,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [3:0]    w_bcd_h, w_bcd_t, w_bcd_o;
    logic [CW-1:0] r_refresh;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_nxt;
    logic          w_wrap;
    logic [6:0]    w_seg_nxt;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .i_bin   (bin),
        .o_bcd_h (w_bcd_h),
        .o_bcd_t (w_bcd_t),
        .o_bcd_o (w_bcd_o),
        .o_busy  (busy)
    );

    assign w_wrap    = (r_refresh == CW'(REFRESH_DIV - 1));
    assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;

    // Decode follows live bcd/letter throughout each slot
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        case (w_idx_nxt)
            2'd0: w_seg_nxt = digit_seg(w_bcd_o);
            2'd1: w_seg_nxt = (BLANK_LEADING && w_bcd_h == 4'd0 && w_bcd_t == 4'd0) ? SEG_BLANK : digit_seg(w_bcd_t);
            2'd2: w_seg_nxt = (BLANK_LEADING && w_bcd_h == 4'd0) ? SEG_BLANK : digit_seg(w_bcd_h);
            2'd3: begin
                case (letter)
                    LTR_ADD_A: w_seg_nxt = SEG_A;
                    LTR_B:     w_seg_nxt = SEG_B_LC;
                    LTR_OP:    w_seg_nxt = SEG_C;
                    LTR_NONE:  w_seg_nxt = SEG_BLANK;
                    default:   w_seg_nxt = SEG_DASH;
                endcase
            end
            default: w_seg_nxt = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_an      <= 4'b1110;
            r_seg     <= SEG_0;
        end else begin
            r_refresh <= w_wrap ? '0 : r_refresh + CW'(1);
            r_idx     <= w_idx_nxt;
            r_an      <= ~(4'b0001 << w_idx_nxt);
            r_seg     <= w_seg_nxt;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = 1'b1;

endmodule
